div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
- Control and sign stage that sits directly upstream of the iterative unsigned 64-bit divide core.
- Accepts RISC-V M-extension divide/remainder requests: DIV, DIVU, REM, REMU and the W variants.
- Resolves divide-by-zero and signed overflow without starting the core.
- Otherwise converts operands to magnitudes, launches the core, waits for completion, applies sign and word fixup, and holds the result until the consumer accepts it.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CORE_TIMEOUT, 0, debug watchdog; 0 = disabled. Nonzero: `err` asserts when WAIT exceeds this many cycles.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_word  in  1  W variant (32-bit operation)
- req_a  in  64  dividend rs1
- req_b  in  64  divisor rs2
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_data  out  64  final rd value
- flush  in  1  pipeline kill; abandon current operation
- core_start  out  1  one-cycle launch pulse to the divide core
- core_dividend  out  64  unsigned magnitude, stable from core_start until core_done
- core_divisor  out  64  unsigned magnitude, stable from core_start until core_done
- core_done  in  1  one-cycle completion pulse from the core
- core_quotient  in  64  unsigned quotient, valid with core_done
- core_remainder  in  64  unsigned remainder, valid with core_done
- err  out  1  sticky watchdog flag; cleared only by reset

Behaviour:
- Reset values: req_ready=0, resp_valid=0, resp_data=0, core_start=0, core_dividend=0, core_divisor=0, err=0, state=IDLE.
- Reset is honoured mid-operation.
- Operand prep:
  - W + signed ops: sign-extend req_a[31:0] and req_b[31:0].
  - W + unsigned ops: zero-extend req_a[31:0] and req_b[31:0].
  - Signed ops: magnitude = two's-complement abs. abs(MIN) = MIN as unsigned.
- Special cases, taking the fast path with no core_start:
  - Divisor == 0: quotient = all ones; remainder = the prepared dividend.
  - Signed with dividend == MIN (64-bit, or 0x8000_0000 for W) and divisor == -1: quotient = MIN; remainder = 0.
- FSM states: IDLE, WAIT, RESP, DRAIN.
  - IDLE: req_ready=1. On req_valid && !flush, latch op/word/signs.
    - Special case: latch the result, go to RESP next cycle.
    - Otherwise: core_start=1 next cycle with magnitudes registered, go to WAIT.
  - WAIT: req_ready=0. On core_done, apply fixup, register resp_data, go to RESP.
  - RESP: resp_valid=1 and resp_data stable. On resp_ready, go to IDLE. No new request is accepted in the same cycle (req_ready is low in RESP).
  - DRAIN: req_ready=0. Wait for core_done, discard the result, go to IDLE.
- Fixup:
  - Quotient is negated iff signed and sign(a) != sign(b).
  - Remainder takes the sign of the dividend when signed.
  - REM/REMU select the remainder; DIV/DIVU select the quotient.
  - W: resp_data = sign-extend(result[31:0]), for unsigned W ops too.
- Latency, with request accepted in cycle N:
  - Special case: resp_valid in N+1.
  - Normal: core_start in N+1; core_done in N+1+L; resp_valid in N+2+L.
- flush, which has priority over every same-cycle event:
  - IDLE: the request is not accepted.
  - WAIT without core_done: go to DRAIN.
  - WAIT with core_done in the same cycle: go to IDLE and drop the result.
  - RESP: go to IDLE and drop resp_valid.
  - DRAIN: no effect.
- core_done outside WAIT/DRAIN is ignored.
- core_start never asserts twice without an intervening core_done.
- Watchdog: if CORE_TIMEOUT>0, count cycles in WAIT/DRAIN; set err when the count exceeds CORE_TIMEOUT. The FSM is otherwise unaffected.

Decomposition:
- Shared package mdu_pkg:
  - div_op_e (DIV, DIVU, REM, REMU)
  - div_state_e (IDLE, WAIT, RESP, DRAIN)
  - constants XLEN_MIN = 64'h8000_0000_0000_0000 and W_MIN = 32'h8000_0000
- One combinational sub-module, div_fixup: signs, op, word, raw quotient/remainder in; final rd value out. It is reused for the special-case path.

Test Plan:
- DIV a=-20, b=3, core returns q=6 r=2 -> core_dividend=20, core_divisor=3; resp_data=-6 (0xFFFF_FFFF_FFFF_FFFA). REM same operands -> -2.
- DIVU b=0, a=0x1234 -> no core_start; resp_valid the cycle after acceptance; resp_data=0xFFFF_FFFF_FFFF_FFFF. REMU same -> 0x1234.
- DIV a=0x8000_0000_0000_0000, b=-1 -> no core_start; resp_data=0x8000_0000_0000_0000. REM same -> 0.
- DIVUW a=0xFFFF_FFFF_FFFF_FFFE, b=1, core returns q=0xFFFF_FFFE -> core_dividend=0x0000_0000_FFFF_FFFE; resp_data=0xFFFF_FFFF_FFFF_FFFE.
- flush two cycles after core_start, core_done five cycles later -> state DRAIN, req_ready=0, no resp_valid; req_ready=1 the cycle after core_done.
- resp_ready held low 10 cycles in RESP -> resp_valid and resp_data stable; a new req_valid is not accepted until the cycle after the resp_ready handshake.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the M-extension divide path
package mdu_pkg;

    localparam logic [63:0] XLEN_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] W_MIN    = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        RESP  = 2'b10,
        DRAIN = 2'b11
    } div_state_e;

    // funct3[0] clear means a signed operation; funct3[1] set selects the remainder
    function automatic logic op_is_signed(logic [1:0] op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(logic [1:0] op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_fixup.sv
// rtl/div_fixup.sv - sign restore, result select and word sign-extension
module div_fixup
    import mdu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic        word,
    input  logic        neg_a,
    input  logic        neg_b,
    input  logic [63:0] quotient,
    input  logic [63:0] remainder,
    output logic [63:0] rd
);

    logic        sgn;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] res;

    always_comb begin
        sgn   = op_is_signed(op);
        q_fix = (sgn && (neg_a != neg_b)) ? (64'd0 - quotient) : quotient;
        r_fix = (sgn && neg_a) ? (64'd0 - remainder) : remainder;
        res   = op_is_rem(op) ? r_fix : q_fix;
        // W results are always sign-extended from bit 31, unsigned W ops included
        rd    = word ? {{32{res[31]}}, res[31:0]} : res;
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sign/control stage in front of the iterative unsigned divide core
module div_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int CORE_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic            req_word,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    input  logic            flush,
    output logic            core_start,
    output logic [XLEN-1:0] core_dividend,
    output logic [XLEN-1:0] core_divisor,
    input  logic            core_done,
    input  logic [XLEN-1:0] core_quotient,
    input  logic [XLEN-1:0] core_remainder,
    output logic            err
);

    div_state_e state_q, state_d;

    logic [1:0]  op_q;
    logic        word_q;
    logic        neg_a_q;
    logic        neg_b_q;

    logic        sgn_in;
    logic [63:0] a_ext, b_ext;
    logic        neg_a_in, neg_b_in;
    logic [63:0] mag_a, mag_b;
    logic        div0, ovf, special;

    logic        accept;
    logic        launch;
    logic        load_resp;

    logic [1:0]  fx_op;
    logic        fx_word, fx_neg_a, fx_neg_b;
    logic [63:0] fx_q, fx_r, fx_rd;

    // operand preparation for the request currently offered
    always_comb begin
        sgn_in = op_is_signed(req_op);
        if (req_word) begin
            a_ext = sgn_in ? {{32{req_a[31]}}, req_a[31:0]} : {32'd0, req_a[31:0]};
            b_ext = sgn_in ? {{32{req_b[31]}}, req_b[31:0]} : {32'd0, req_b[31:0]};
        end else begin
            a_ext = req_a;
            b_ext = req_b;
        end
        neg_a_in = sgn_in && a_ext[63];
        neg_b_in = sgn_in && b_ext[63];
        mag_a    = neg_a_in ? (64'd0 - a_ext) : a_ext;
        mag_b    = neg_b_in ? (64'd0 - b_ext) : b_ext;
        div0     = (b_ext == 64'd0);
        ovf      = sgn_in && (&b_ext) &&
                   (req_word ? (a_ext[31:0] == W_MIN) : (a_ext == XLEN_MIN));
        special  = div0 || ovf;
    end

    // The fast path reuses the fixup: the magnitude comes back with the dividend's
    // sign restored, and forcing equal signs keeps the all-ones quotient unnegated.
    always_comb begin
        if (state_q == IDLE) begin
            fx_op    = req_op;
            fx_word  = req_word;
            fx_neg_a = neg_a_in;
            fx_neg_b = div0 ? neg_a_in : neg_b_in;
            fx_q     = div0 ? 64'hFFFF_FFFF_FFFF_FFFF : mag_a;
            fx_r     = div0 ? mag_a : 64'd0;
        end else begin
            fx_op    = op_q;
            fx_word  = word_q;
            fx_neg_a = neg_a_q;
            fx_neg_b = neg_b_q;
            fx_q     = core_quotient;
            fx_r     = core_remainder;
        end
    end

    div_fixup u_fixup (
        .op        (fx_op),
        .word      (fx_word),
        .neg_a     (fx_neg_a),
        .neg_b     (fx_neg_b),
        .quotient  (fx_q),
        .remainder (fx_r),
        .rd        (fx_rd)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        launch     = 1'b0;
        load_resp  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                accept = req_ready && req_valid && !flush;
                if (accept) begin
                    launch    = !special;
                    load_resp = special;
                    state_d   = special ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = core_done ? IDLE : DRAIN;
                end else if (core_done) begin
                    load_resp = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            req_ready     <= 1'b0;
            core_start    <= 1'b0;
            core_dividend <= 64'd0;
            core_divisor  <= 64'd0;
            resp_data     <= 64'd0;
            op_q          <= 2'b00;
            word_q        <= 1'b0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == IDLE);
            core_start <= launch;
            if (accept) begin
                op_q    <= req_op;
                word_q  <= req_word;
                neg_a_q <= neg_a_in;
                neg_b_q <= neg_b_in;
            end
            if (launch) begin
                core_dividend <= mag_a;
                core_divisor  <= mag_b;
            end
            if (load_resp) begin
                resp_data <= fx_rd;
            end
        end
    end

    generate
        if (CORE_TIMEOUT > 0) begin : g_watchdog
            localparam logic [31:0] TIMEOUT_W = 32'(CORE_TIMEOUT);
            logic [31:0] wd_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    wd_cnt <= 32'd0;
                    err    <= 1'b0;
                end else if ((state_q == WAIT) || (state_q == DRAIN)) begin
                    if (wd_cnt != 32'hFFFF_FFFF) begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                    // wd_cnt holds the cycles already spent, so this is the (TIMEOUT+1)th
                    if (wd_cnt >= TIMEOUT_W) begin
                        err <= 1'b1;
                    end
                end else begin
                    wd_cnt <= 32'd0;
                end
            end
        end else begin : g_no_watchdog
            assign err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - randomized self-checking bench for div_seq_ctrl
module tb_div_seq_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_word;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        flush;
    logic        core_start;
    logic [63:0] core_dividend;
    logic [63:0] core_divisor;
    logic        core_done;
    logic [63:0] core_quotient;
    logic [63:0] core_remainder;
    logic        err;

    int tests_run    = 0;
    int tests_failed = 0;

    div_seq_ctrl #(.XLEN(64), .CORE_TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_word       (req_word),
        .req_a          (req_a),
        .req_b          (req_b),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .flush          (flush),
        .core_start     (core_start),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics computed with plain signed/unsigned arithmetic
    function automatic logic ref_special(logic [1:0] op, logic w, logic [63:0] a, logic [63:0] b);
        logic sgn;
        sgn = !op[0];
        if (w)
            return (b[31:0] == 32'd0) ||
                   (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) ||
               (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    endfunction

    function automatic logic [63:0] ref_rd(logic [1:0] op, logic w, logic [63:0] a, logic [63:0] b);
        logic        sgn;
        logic        rem;
        logic [31:0] ua, ub, q32, r32, res32;
        int          sa, sb;
        logic [63:0] q, r;
        longint      la, lb;
        sgn = !op[0];
        rem = op[1];
        if (w) begin
            ua = a[31:0];
            ub = b[31:0];
            sa = $signed(ua);
            sb = $signed(ub);
            if (ub == 32'd0) begin
                q32 = 32'hFFFF_FFFF;
                r32 = sgn ? 32'(sa) : ua;
            end else if (sgn && sa == 32'sh8000_0000 && sb == -1) begin
                q32 = ua;
                r32 = 32'd0;
            end else if (sgn) begin
                q32 = 32'(sa / sb);
                r32 = 32'(sa % sb);
            end else begin
                q32 = ua / ub;
                r32 = ua % ub;
            end
            res32 = rem ? r32 : q32;
            return {{32{res32[31]}}, res32};
        end
        la = $signed(a);
        lb = $signed(b);
        if (b == 64'd0) begin
            q = 64'hFFFF_FFFF_FFFF_FFFF;
            r = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && lb == -64'sd1) begin
            q = a;
            r = 64'd0;
        end else if (sgn) begin
            q = 64'(la / lb);
            r = 64'(la % lb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    function automatic logic [63:0] ref_mag(logic [1:0] op, logic w, logic [63:0] x);
        logic [63:0] e;
        longint      v;
        if (w) e = op[0] ? {32'd0, x[31:0]} : {{32{x[31]}}, x[31:0]};
        else   e = x;
        if (op[0]) return e;
        v = $signed(e);
        if (v < 0) v = -v;
        return 64'(v);
    endfunction

    // One full transaction: request, optional core emulation with latency lat,
    // response held for hold cycles while a competing request is offered.
    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int lat, input int hold,
                          output logic [63:0] got);
        logic [63:0] exp_rd, dvd, dvs;
        logic        sp;
        int          waited;
        exp_rd = ref_rd(op, w, a, b);
        sp     = ref_special(op, w, a, b);
        dvd    = ref_mag(op, w, a);
        dvs    = ref_mag(op, w, b);
        @(negedge clk);
        req_op = op; req_word = w; req_a = a; req_b = b; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_timeout req_ready=%b exp=1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (sp) begin
            tests_run++;
            if (core_start !== 1'b0 || resp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL fast_path core_start=%b resp_valid=%b exp 0/1", core_start, resp_valid);
            end
        end else begin
            tests_run++;
            if (core_start !== 1'b1 || core_dividend !== dvd || core_divisor !== dvs) begin
                tests_failed++;
                $display("FAIL core_launch start=%b dvd=%h dvs=%h exp 1 %h %h",
                         core_start, core_dividend, core_divisor, dvd, dvs);
            end
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                tests_run++;
                if (core_start !== 1'b0 || resp_valid !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL core_wait start=%b resp_valid=%b exp 0/0", core_start, resp_valid);
                end
            end
            core_done = 1'b1;
            core_quotient  = dvd / dvs;
            core_remainder = dvd % dvs;
            @(negedge clk);
            core_done = 1'b0;
            core_quotient  = {$urandom, $urandom};
            core_remainder = {$urandom, $urandom};
            tests_run++;
            if (resp_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL resp_latency resp_valid=%b exp=1", resp_valid);
            end
        end
        tests_run++;
        if (resp_data !== exp_rd) begin
            tests_failed++;
            $display("FAIL resp_data op=%0d w=%b a=%h b=%h got=%h exp=%h", op, w, a, b, resp_data, exp_rd);
        end
        got = resp_data;
        req_op = 2'b01; req_word = 1'b0; req_b = 64'd0; req_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            tests_run++;
            if (resp_valid !== 1'b1 || resp_data !== exp_rd || req_ready !== 1'b0 || core_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL resp_hold valid=%b data=%h ready=%b exp 1 %h 0", resp_valid, resp_data, req_ready, exp_rd);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b0 || core_start !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL resp_handshake valid=%b start=%b ready=%b exp 0 0 1", resp_valid, core_start, req_ready);
        end
        req_valid = 1'b0;
    endtask

    task automatic start_normal(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        int waited;
        @(negedge clk);
        req_op = op; req_word = 1'b0; req_a = a; req_b = b; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (core_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_normal core_start=%b exp=1", core_start);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_word = 1'b0;
        req_a = 64'd0; req_b = 64'd0; resp_ready = 1'b0; flush = 1'b0;
        core_done = 1'b0; core_quotient = 64'd0; core_remainder = 64'd0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 64'd0 || core_start !== 1'b0 ||
            core_dividend !== 64'd0 || core_divisor !== 64'd0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values ready=%b valid=%b data=%h start=%b dvd=%h dvs=%h err=%b exp all 0",
                     req_ready, resp_valid, resp_data, core_start, core_dividend, core_divisor, err);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release req_ready=%b exp=1", req_ready);
        end
    endtask

    task automatic test_directed();
        logic [63:0] got;
        logic [63:0] exp_c [10];
        logic [63:0] got_c [10];
        exp_c = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h1234, 64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9};
        run_op(2'b00, 1'b0, -64'sd20, 64'd3, 3, 0, got);                 got_c[0] = got;
        run_op(2'b10, 1'b0, -64'sd20, 64'd3, 2, 1, got);                 got_c[1] = got;
        run_op(2'b01, 1'b0, 64'h1234, 64'd0, 0, 0, got);                 got_c[2] = got;
        run_op(2'b11, 1'b0, 64'h1234, 64'd0, 0, 2, got);                 got_c[3] = got;
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 0, 0, got); got_c[4] = got;
        run_op(2'b10, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 0, 0, got); got_c[5] = got;
        run_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 4, 0, got);  got_c[6] = got;
        run_op(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 0, 0, got); got_c[7] = got;
        run_op(2'b00, 1'b0, -64'sd7, 64'd0, 0, 0, got);                  got_c[8] = got;
        run_op(2'b10, 1'b0, -64'sd7, 64'd0, 0, 0, got);                  got_c[9] = got;
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if (got_c[i] !== exp_c[i]) begin
                tests_failed++;
                $display("FAIL directed_%0d got=%h exp=%h", i, got_c[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_flush_drain();
        start_normal(2'b00, 64'd100, 64'd7);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b0 || core_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_hold ready=%b valid=%b start=%b exp 0 0 0", req_ready, resp_valid, core_start);
            end
            if (i == 2) flush = 1'b1;
            if (i < 3) @(negedge clk);
            flush = 1'b0;
        end
        core_done = 1'b1; core_quotient = 64'd14; core_remainder = 64'd2;
        @(negedge clk);
        core_done = 1'b0;
        tests_run++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain_exit ready=%b valid=%b exp 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_flush_events();
        start_normal(2'b01, 64'd50, 64'd5);
        @(negedge clk);
        core_done = 1'b1; flush = 1'b1; core_quotient = 64'd10; core_remainder = 64'd0;
        @(negedge clk);
        core_done = 1'b0; flush = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_with_done valid=%b ready=%b exp 0 1", resp_valid, req_ready);
        end
        req_op = 2'b01; req_a = 64'd9; req_b = 64'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fast_accept valid=%b exp 1", resp_valid);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_resp valid=%b ready=%b exp 0 1", resp_valid, req_ready);
        end
        req_op = 2'b00; req_a = 64'd9; req_b = 64'd2; req_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        tests_run++;
        if (core_start !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle start=%b valid=%b ready=%b exp 0 0 1", core_start, resp_valid, req_ready);
        end
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b0 || core_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_done valid=%b start=%b exp 0 0", resp_valid, core_start);
        end
    endtask

    task automatic test_reset_mid_op();
        start_normal(2'b00, 64'd77, 64'd5);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 1'b0 || core_start !== 1'b0 || core_dividend !== 64'd0 ||
            resp_valid !== 1'b0 || resp_data !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_op ready=%b start=%b dvd=%h valid=%b data=%h exp all 0",
                     req_ready, core_start, core_dividend, resp_valid, resp_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [63:0] got, a, b;
        logic [1:0]  op;
        logic        w;
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: a = 64'd0;
                1: a = 64'hFFFF_FFFF_FFFF_FFFF;
                2: a = 64'h8000_0000_0000_0000;
                3: a = {$urandom, 32'h8000_0000};
                4: a = 64'($signed($urandom_range(0, 100)) - 50);
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: b = {$urandom, 32'd0};
                1: b = 64'hFFFF_FFFF_FFFF_FFFF;
                2: b = 64'd1;
                3: b = 64'($signed($urandom_range(1, 20)) - 30);
                4: b = {32'd0, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            run_op(op, w, a, b, $urandom_range(0, 6), $urandom_range(0, 3), got);
        end
    endtask

    task automatic test_watchdog();
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_before_timeout err=%b exp=0", err);
        end
        start_normal(2'b01, 64'd1000, 64'd3);
        for (int k = 2; k <= 50; k++) begin
            @(negedge clk);
            if (k == TIMEOUT + 1) begin
                tests_run++;
                if (err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL err_at_limit err=%b exp=0", err);
                end
            end
            if (k == TIMEOUT + 2) begin
                tests_run++;
                if (err !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL err_past_limit err=%b exp=1", err);
                end
            end
        end
        core_done = 1'b1; core_quotient = 64'd333; core_remainder = 64'd1;
        @(negedge clk);
        core_done = 1'b0;
        tests_run++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd333) begin
            tests_failed++;
            $display("FAIL watchdog_result valid=%b data=%h exp 1 %h", resp_valid, resp_data, 64'd333);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky err=%b exp=1", err);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_reset err=%b exp=0", err);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_drain();
        test_flush_events();
        test_reset_mid_op();
        test_random();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
